mlp_output_sequencer: RTL and testbench
=======================================

# mlp_output_sequencer

Control sequencer for the MLP output layer. It accepts a software "go" over an Avalon-MM slave and issues a one-cycle start pulse to the output layer. It then waits for the layer's finished flag, snapshots the logits, and scans them serially to produce the predicted class. It sits between the host CSR bus and the output_layer datapath, and replaces the bare start-register wrapper around it.

## Interface
- OUTPUT_SIZE, 10, number of logits/classes
- ACC_W, 64, width of each signed logit
- IDX_W, 4, class index width; must satisfy 2**IDX_W >= OUTPUT_SIZE
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT (used only when the watchdog is compiled in)

Ports:
- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- avmm_address  in  3  CSR word address
- avmm_writedata  in  32  CSR write data
- avmm_write  in  1  write strobe
- avmm_read  in  1  read strobe
- avmm_readdata  out  32  registered read data
- avmm_waitrequest  out  1  tied 0 (never stalls)
- layer_start  out  1  one-cycle start pulse to output_layer
- layer_finished  in  1  output_layer finished flag (level)
- logits_flat  in  ACC_W*OUTPUT_SIZE  signed logits; logit i is at [i*ACC_W +: ACC_W]
- class_idx  out  IDX_W  argmax of the last completed run
- one_hot  out  OUTPUT_SIZE  one-hot encoding of class_idx
- done_irq  out  1  level interrupt: done & irq_en

## Operation
- CSR map (word addresses):
  - 0 CTRL: W bit0 go (self-clearing); bit1 irq_en (R/W); bit2 done_clr (W1C of done).
  - 1 STATUS (RO): bit0 busy, bit1 done, bit2 timeout.
  - 2 CLASS (RO): class_idx, zero-extended.
  - 3 CYCLES (RO): start-to-finished cycle count of the last run, saturating at 32'hFFFF_FFFF.
  - 4 MAXLO (RO): max logit [31:0].
  - 5 MAXHI (RO): max logit [63:32], or sign extension when ACC_W < 64.
  - Other addresses read 0; writes to them are ignored.
- FSM states: IDLE, PULSE, WAIT, SCAN.
  - IDLE + go: clear done and timeout, go to PULSE.
  - PULSE: layer_start=1 for exactly one cycle; clear cycle counter; go to WAIT.
  - WAIT: increment cycle counter each cycle. When layer_finished=1 is sampled, register all logits into a snapshot and go to SCAN.
  - SCAN: compare snapshot[k] for k = 0..OUTPUT_SIZE-1, one per cycle, using a signed strict greater-than, so ties keep the lowest index. After the last compare: update class_idx, one_hot and max logit, set done, go to IDLE.
- A go received while busy (any state except IDLE) is ignored.
- A go and a done_clr in the same write: the go wins and done is cleared.
- The outputs class_idx, one_hot and max logit change only at SCAN completion, and hold across later runs until the next completion.

## Timing
- Reset values:
  - Outputs: avmm_readdata=0, avmm_waitrequest=0, layer_start=0, class_idx=0, done_irq=0.
  - one_hot=0 (it is 0 only until the first completion).
  - Internal: state=IDLE, done=0, timeout=0, irq_en=0, CYCLES=0, max logit=0.
- Reset asserted mid-run returns the block to IDLE on the next edge. layer_start deasserts in that same edge.
- Reads have 1-cycle latency: readdata is valid on the cycle after avmm_read. It returns 0 when avmm_read was low.
- Cycle timeline, with the go write sampled at edge 0:
  - layer_start is high in the cycle after edge 0.
  - With layer_finished first sampled high at edge F, results and done are valid after edge F+OUTPUT_SIZE+1.
- busy=1 from edge 0 until done is set.
- layer_finished is ignored outside WAIT.

## Configuration
- Macro MLP_OUTPUT_SEQ_TIMEOUT_EN:
  - Defined: WAIT aborts when the cycle counter reaches TIMEOUT_CYCLES-1. The abort sets timeout=1 and done=0, returns to IDLE, and leaves the results unchanged. The timeout condition also drives done_irq when irq_en=1.
  - Undefined: WAIT waits indefinitely, and the timeout bit reads 0.

## Structure
- Shared package mlp_pkg holds:
  - the state enum typedef;
  - CSR address localparams: CTRL, STATUS, CLASS, CYCLES, MAXLO, MAXHI;
  - CTRL/STATUS bit position constants.
- One sub-module, mlp_argmax_scan: serial signed argmax over the snapshot, with start/done handshake, outputs idx and max.
- The CSR decode and FSM stay in the top module.

## Test plan
- Go with logits {3,-1,7,7,0,2,-5,1,6,4} and finished raised 5 cycles after layer_start -> class_idx=2, one_hot=10'b0000000100, CYCLES=5, MAXLO=7, done=1.
- All logits = -2^63 (most negative) -> class_idx=0, MAXHI=32'h8000_0000, MAXLO=0.
- Go while in WAIT -> no second layer_start pulse; the run completes once.
- irq_en=1, run completes -> done_irq=1; write done_clr -> done_irq=0 on the next cycle.
- Macro defined, TIMEOUT_CYCLES=16, finished never asserted -> timeout=1 after 16 WAIT cycles, done=0, class_idx unchanged.
- reset_n low during SCAN -> IDLE, class_idx=0, busy=0; a subsequent go runs normally.

Source files
------------

// File: rtl/mlp_pkg.sv
// Purpose: shared types and constants for the MLP output-layer sequencer (FSM states, CSR map, bit positions).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mlp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SCAN  = 2'd3
    } seq_state_t;

    // CSR word addresses
    localparam logic [2:0] CSR_CTRL   = 3'd0;
    localparam logic [2:0] CSR_STATUS = 3'd1;
    localparam logic [2:0] CSR_CLASS  = 3'd2;
    localparam logic [2:0] CSR_CYCLES = 3'd3;
    localparam logic [2:0] CSR_MAXLO  = 3'd4;
    localparam logic [2:0] CSR_MAXHI  = 3'd5;

    // CTRL bits
    localparam int CTRL_GO_BIT       = 0;
    localparam int CTRL_IRQ_EN_BIT   = 1;
    localparam int CTRL_DONE_CLR_BIT = 2;

    // STATUS bits
    localparam int STAT_BUSY_BIT     = 0;
    localparam int STAT_DONE_BIT     = 1;
    localparam int STAT_TIMEOUT_BIT  = 2;

endpackage

// File: rtl/mlp_argmax_scan.sv
// Purpose: serial signed argmax over a flat logit vector, one element per cycle; ties keep the lowest index.
// Latency: done pulses N cycles after start; idx/max_val valid from done onward until the next start.
// Backpressure: none; start restarts the scan, vals_flat must stay stable while scanning.
// Ports: clk, reset_n (sync, active-low), start, vals_flat in; done, idx, max_val out.
module mlp_argmax_scan
    import mlp_pkg::*;
#(
    parameter int N     = 10,
    parameter int ACC_W = 64,
    parameter int IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ACC_W*N-1:0]   vals_flat,
    output logic                 done,
    output logic [IDX_W-1:0]     idx,
    output logic [ACC_W-1:0]     max_val
);

    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N - 1);

    logic                    run_q,  run_d;
    logic                    done_q, done_d;
    logic [IDX_W-1:0]        k_q,    k_d;
    logic [IDX_W-1:0]        bidx_q, bidx_d;
    logic signed [ACC_W-1:0] best_q, best_d;
    logic signed [ACC_W-1:0] cur;
    logic                    take;

    always_comb begin
        run_d  = run_q;
        done_d = 1'b0;
        k_d    = k_q;
        bidx_d = bidx_q;
        best_d = best_q;
        cur    = vals_flat[k_q*ACC_W +: ACC_W];
        // Element 0 always seeds the running max; strict > keeps the first of equal values.
        take   = (k_q == '0) || (cur > best_q);

        if (start) begin
            run_d = 1'b1;
            k_d   = '0;
        end else if (run_q) begin
            if (take) begin
                best_d = cur;
                bidx_d = k_q;
            end
            if (k_q == LAST_K) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            k_q    <= '0;
            bidx_q <= '0;
            best_q <= '0;
        end else begin
            run_q  <= run_d;
            done_q <= done_d;
            k_q    <= k_d;
            bidx_q <= bidx_d;
            best_q <= best_d;
        end
    end

    assign done    = done_q;
    assign idx     = bidx_q;
    assign max_val = best_q;

endmodule

// File: rtl/mlp_output_sequencer.sv
// Purpose: CSR-driven start/wait/argmax sequencer for the MLP output layer (Avalon-MM slave, FSM, result registers).
// Latency: layer_start 1 cycle after go; results/done OUTPUT_SIZE+1 cycles after layer_finished is sampled; reads 1 cycle.
// Backpressure: avmm_waitrequest tied 0; go while busy is dropped. Optional watchdog: MLP_OUTPUT_SEQ_TIMEOUT_EN.
// Ports: clk, reset_n (sync, active-low); avmm_* CSR slave; layer_start/layer_finished/logits_flat to the layer;
//        class_idx, one_hot, done_irq results.
module mlp_output_sequencer
    import mlp_pkg::*;
#(
    parameter int OUTPUT_SIZE    = 10,
    parameter int ACC_W          = 64,
    parameter int IDX_W          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [2:0]                   avmm_address,
    input  logic [31:0]                  avmm_writedata,
    input  logic                         avmm_write,
    input  logic                         avmm_read,
    output logic [31:0]                  avmm_readdata,
    output logic                         avmm_waitrequest,
    output logic                         layer_start,
    input  logic                         layer_finished,
    input  logic [ACC_W*OUTPUT_SIZE-1:0] logits_flat,
    output logic [IDX_W-1:0]             class_idx,
    output logic [OUTPUT_SIZE-1:0]       one_hot,
    output logic                         done_irq
);

`ifdef MLP_OUTPUT_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    seq_state_t                   state_q, state_d;
    logic                         irq_en_q, irq_en_d;
    logic                         done_q, done_d;
    logic                         timeout_q, timeout_d;
    logic [31:0]                  cnt_q, cnt_d;
    logic [ACC_W*OUTPUT_SIZE-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]             class_q, class_d;
    logic [OUTPUT_SIZE-1:0]       onehot_q, onehot_d;
    logic [ACC_W-1:0]             max_q, max_d;
    logic [31:0]                  rdata_q, rdata_d;

    logic                         ctrl_wr, go, scan_start, scan_done;
    logic [IDX_W-1:0]             scan_idx;
    logic [ACC_W-1:0]             scan_max;
    logic [63:0]                  max_ext;
    logic                         unused_wdata;

    assign unused_wdata = ^avmm_writedata[31:3];

    mlp_argmax_scan #(.N(OUTPUT_SIZE), .ACC_W(ACC_W), .IDX_W(IDX_W)) u_scan (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (scan_start),
        .vals_flat (snap_q),
        .done      (scan_done),
        .idx       (scan_idx),
        .max_val   (scan_max)
    );

    // Sign-extend (or truncate) the max logit to the 64-bit MAXHI:MAXLO view.
    assign max_ext = 64'($signed(max_q));

    assign ctrl_wr = avmm_write && (avmm_address == CSR_CTRL);
    assign go      = ctrl_wr && avmm_writedata[CTRL_GO_BIT];

    always_comb begin
        state_d    = state_q;
        irq_en_d   = irq_en_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        class_d    = class_q;
        onehot_d   = onehot_q;
        max_d      = max_q;
        scan_start = 1'b0;

        if (ctrl_wr) begin
            irq_en_d = avmm_writedata[CTRL_IRQ_EN_BIT];
            if (avmm_writedata[CTRL_DONE_CLR_BIT]) begin
                done_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = ST_PULSE;
                end
            end
            ST_PULSE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The finishing cycle is counted too.
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 32'd1;
                end
                if (layer_finished) begin
                    snap_d     = logits_flat;
                    scan_start = 1'b1;
                    state_d    = ST_SCAN;
                end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (scan_done) begin
                    class_d  = scan_idx;
                    onehot_d = OUTPUT_SIZE'(1) << scan_idx;
                    max_d    = scan_max;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        if (avmm_read) begin
            case (avmm_address)
                CSR_CTRL:   rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
                CSR_STATUS: begin
                    rdata_d[STAT_BUSY_BIT]    = (state_q != ST_IDLE);
                    rdata_d[STAT_DONE_BIT]    = done_q;
                    rdata_d[STAT_TIMEOUT_BIT] = timeout_q;
                end
                CSR_CLASS:  rdata_d = 32'(class_q);
                CSR_CYCLES: rdata_d = cnt_q;
                CSR_MAXLO:  rdata_d = max_ext[31:0];
                CSR_MAXHI:  rdata_d = max_ext[63:32];
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            class_q   <= '0;
            onehot_q  <= '0;
            max_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            class_q   <= class_d;
            onehot_q  <= onehot_d;
            max_q     <= max_d;
            rdata_q   <= rdata_d;
        end
    end

    // Snapshot is pure data, only meaningful after a WAIT capture.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign avmm_readdata    = rdata_q;
    assign avmm_waitrequest = 1'b0;
    assign layer_start      = (state_q == ST_PULSE);
    assign class_idx        = class_q;
    assign one_hot          = onehot_q;
    assign done_irq         = irq_en_q & (done_q | timeout_q);

endmodule

// File: tb/tb_mlp_output_sequencer.sv
// Purpose: self-checking bench for mlp_output_sequencer; argmax reference model over random and directed logits.
// Latency: n/a.
// Backpressure: n/a.
module tb_mlp_output_sequencer;

    localparam int N  = 10;
    localparam int AW = 64;
    localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_CLASS = 3'd2,
                           A_CYCLES = 3'd3, A_MAXLO = 3'd4, A_MAXHI = 3'd5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [2:0]        avmm_address;
    logic [31:0]       avmm_writedata;
    logic              avmm_write;
    logic              avmm_read;
    logic [31:0]       avmm_readdata;
    logic              avmm_waitrequest;
    logic              layer_start;
    logic              layer_finished;
    logic [AW*N-1:0]   logits_flat;
    logic [3:0]        class_idx;
    logic [N-1:0]      one_hot;
    logic              done_irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint      lg [N];
    int          mdl_class;
    logic [63:0] mdl_max;
    logic [31:0] mdl_cycles;
    bit          mdl_irq;
    bit          mdl_done;

    mlp_output_sequencer #(
        .OUTPUT_SIZE(N), .ACC_W(AW), .IDX_W(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .avmm_address     (avmm_address),
        .avmm_writedata   (avmm_writedata),
        .avmm_write       (avmm_write),
        .avmm_read        (avmm_read),
        .avmm_readdata    (avmm_readdata),
        .avmm_waitrequest (avmm_waitrequest),
        .layer_start      (layer_start),
        .layer_finished   (layer_finished),
        .logits_flat      (logits_flat),
        .class_idx        (class_idx),
        .one_hot          (one_hot),
        .done_irq         (done_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks are entered and left 1ns after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        avmm_address   = a;
        avmm_writedata = d;
        avmm_write     = 1'b1;
        tick();
        avmm_write     = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
        avmm_address = a;
        avmm_read    = 1'b1;
        tick();
        avmm_read    = 1'b0;
        check(tag, avmm_readdata, exp);
    endtask

    function automatic logic [N-1:0] exp_onehot(input int c);
        logic [N-1:0] oh;
        oh    = '0;
        oh[c] = 1'b1;
        return oh;
    endfunction

    task automatic load_logits();
        for (int i = 0; i < N; i++) logits_flat[i*AW +: AW] = lg[i];
    endtask

    task automatic model_reset();
        mdl_class  = 0;
        mdl_max    = '0;
        mdl_cycles = '0;
        mdl_irq    = 1'b0;
        mdl_done   = 1'b0;
    endtask

    // Full run: finished raised d cycles after the layer_start cycle, optional go during WAIT.
    task automatic do_run(input string tag, input int d, input bit go_mid, input bit irq);
        int     starts;
        int     e_idx;
        longint e_max;
        e_idx = 0;
        e_max = lg[0];
        for (int i = 1; i < N; i++) begin
            if (lg[i] > e_max) begin
                e_max = lg[i];
                e_idx = i;
            end
        end
        load_logits();
        csr_write(A_CTRL, {29'd0, 1'b0, irq, 1'b1});
        mdl_irq  = irq;
        mdl_done = 1'b0;
        starts   = int'(layer_start);
        for (int i = 1; i <= d; i++) begin
            if (go_mid && i == 2) begin
                avmm_address   = A_CTRL;
                avmm_writedata = {29'd0, 1'b0, irq, 1'b1};
                avmm_write     = 1'b1;
            end
            tick();
            avmm_write = 1'b0;
            starts += int'(layer_start);
        end
        layer_finished = 1'b1;
        tick();
        starts += int'(layer_start);
        for (int i = 0; i < N; i++) begin
            tick();
            starts += int'(layer_start);
            layer_finished = 1'b0;
        end
        check({tag, "_irq_early"}, done_irq, 0);
        check({tag, "_class_hold"}, class_idx, mdl_class);
        tick();
        starts += int'(layer_start);
        mdl_class  = e_idx;
        mdl_max    = e_max;
        mdl_cycles = d;
        mdl_done   = 1'b1;
        check({tag, "_starts"}, starts, 1);
        check({tag, "_class"}, class_idx, mdl_class);
        check({tag, "_onehot"}, one_hot, exp_onehot(mdl_class));
        check({tag, "_irq"}, done_irq, mdl_irq);
        check_read({tag, "_status"}, A_STATUS, 32'h2);
        check_read({tag, "_rd_class"}, A_CLASS, mdl_class);
        check_read({tag, "_cycles"}, A_CYCLES, mdl_cycles);
        check_read({tag, "_maxlo"}, A_MAXLO, mdl_max[31:0]);
        check_read({tag, "_maxhi"}, A_MAXHI, mdl_max[63:32]);
    endtask

    initial begin
        reset_n        = 1'b0;
        avmm_address   = '0;
        avmm_writedata = '0;
        avmm_write     = 1'b0;
        avmm_read      = 1'b0;
        layer_finished = 1'b0;
        logits_flat    = '0;
        model_reset();
        repeat (3) tick();

        // Reset state
        check("rst_start", layer_start, 0);
        check("rst_class", class_idx, 0);
        check("rst_onehot", one_hot, 0);
        check("rst_irq", done_irq, 0);
        check("rst_wait", avmm_waitrequest, 0);
        check("rst_rdata", avmm_readdata, 0);
        reset_n = 1'b1;
        tick();
        check_read("rst_status", A_STATUS, 32'h0);
        check_read("rst_cycles", A_CYCLES, 32'h0);
        check_read("rst_ctrl", A_CTRL, 32'h0);
        tick();
        check("rdata_idle_zero", avmm_readdata, 0);

        // Directed: mixed logits with a tie at 7
        lg = '{3, -1, 7, 7, 0, 2, -5, 1, 6, 4};
        do_run("basic", 5, 1'b0, 1'b0);
        check_read("unmapped", 3'd6, 32'h0);

        // Directed: all most-negative
        for (int i = 0; i < N; i++) lg[i] = 64'h8000_0000_0000_0000;
        do_run("allneg", 3, 1'b0, 1'b0);

        // Directed: go during WAIT is dropped
        lg = '{0, 9, -4, 12, 12, 3, 1, 11, -20, 5};
        do_run("go_mid", 6, 1'b1, 1'b0);

        // Directed: interrupt then done_clr
        lg = '{-8, -3, -3, -9, -1, -7, -2, -6, -1, -4};
        do_run("irq", 4, 1'b0, 1'b1);
        csr_write(A_CTRL, {29'd0, 1'b1, 1'b1, 1'b0});
        mdl_done = 1'b0;
        check("irq_cleared", done_irq, 0);
        check_read("irq_ctrl", A_CTRL, 32'h2);
        check_read("irq_status", A_STATUS, 32'h0);

        // Reset during PULSE drops layer_start on the same edge
        csr_write(A_CTRL, 32'h1);
        check("pulse_hi", layer_start, 1);
        reset_n = 1'b0;
        tick();
        check("pulse_rst", layer_start, 0);
        reset_n = 1'b1;
        model_reset();
        tick();

        // Reset during SCAN
        lg = '{1, 2, 3, 4, 50, 6, 7, 8, 9, 10};
        do_run("pre_scan", 2, 1'b0, 1'b0);
        lg = '{100, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        load_logits();
        csr_write(A_CTRL, 32'h1);
        repeat (3) tick();
        layer_finished = 1'b1;
        tick();
        layer_finished = 1'b0;
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_reset();
        check("scanrst_class", class_idx, 0);
        check("scanrst_onehot", one_hot, 0);
        check("scanrst_start", layer_start, 0);
        check_read("scanrst_status", A_STATUS, 32'h0);
        check_read("scanrst_maxlo", A_MAXLO, 32'h0);
        do_run("after_rst", 3, 1'b0, 1'b0);

`ifdef MLP_OUTPUT_SEQ_TIMEOUT_EN
        // Watchdog: finished never raised
        csr_write(A_CTRL, 32'h3);
        mdl_irq  = 1'b1;
        mdl_done = 1'b0;
        repeat (16) tick();
        check("to_early_irq", done_irq, 0);
        tick();
        check("to_irq", done_irq, 1);
        check("to_class", class_idx, mdl_class);
        check_read("to_status", A_STATUS, 32'h4);
`endif

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1)
                    lg[i] = longint'($urandom_range(0, 6)) - 3;
                else
                    lg[i] = longint'({$urandom, $urandom});
            end
            do_run("rand", int'($urandom_range(2, 12)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
